// File: rtl/rs_issue_sched.sv
// Reservation-station allocation and issue scheduler: tracks entry occupancy, readiness
// and relative age, hands out dispatch slots and binds up to three ready entries per cycle to free units.
module rs_issue_sched #(
    parameter int RS_SIZE  = 16,
    parameter int IDX_W    = 4,
    parameter int MULT_LAT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    input  logic [2:0]             disp_valid,
    input  logic [2:0][1:0]        disp_class,
    input  logic [2:0]             disp_ready,
    output logic [2:0][IDX_W-1:0]  disp_idx,
    output logic [2:0]             struct_stall,
    input  logic [RS_SIZE-1:0]     wake,
    input  logic [2:0]             alu_stall,
    input  logic                   branch_stall,
    input  logic [1:0]             ls_done,
    output logic [2:0]             issue_valid,
    output logic [2:0][IDX_W-1:0]  issue_idx,
    output logic [2:0][2:0]        issue_fu,
    output logic [IDX_W:0]         free_count
);

    localparam int CW = $clog2(MULT_LAT) + 1;
    localparam int FW = IDX_W + 1;

    logic [RS_SIZE-1:0]               valid;
    logic [RS_SIZE-1:0]               ready;
    logic [RS_SIZE-1:0][1:0]          cls;
    logic [RS_SIZE-1:0][RS_SIZE-1:0]  age;   // age[i][j]: entry i is older than entry j
    logic [1:0][CW-1:0]               mult_cnt;
    logic [1:0]                       ls_busy;

    logic [RS_SIZE-1:0]               alloc_en;
    logic [RS_SIZE-1:0]               alloc_rdy;
    logic [RS_SIZE-1:0][1:0]          alloc_rank;
    logic [RS_SIZE-1:0][1:0]          alloc_cls;

    logic [7:0]                       avail;
    logic [3:0]                       class_ok;
    logic [RS_SIZE-1:0]               cand;
    logic [RS_SIZE-1:0]               taken;
    logic                             found;
    logic                             older;
    logic [IDX_W-1:0]                 pick;
    logic [2:0]                       unit;
    logic [7:0]                       fu_issued;

    function automatic logic [2:0] first_unit(input logic [1:0] c, input logic [7:0] av);
        case (c)
            2'd0:    first_unit = av[0] ? 3'd0 : (av[1] ? 3'd1 : 3'd2);
            2'd1:    first_unit = av[3] ? 3'd3 : 3'd4;
            2'd2:    first_unit = av[5] ? 3'd5 : 3'd6;
            default: first_unit = 3'd7;
        endcase
    endfunction

    // Slot k takes the k-th lowest entry that is invalid at cycle start.
    always_comb begin
        free_count = '0;
        disp_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!valid[i]) begin
                for (int k = 0; k < 3; k++) begin
                    if (free_count == FW'(k)) disp_idx[k] = IDX_W'(i);
                end
                free_count = free_count + FW'(1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            struct_stall[k] = (free_count <= FW'(k));
        end
    end

    always_comb begin
        alloc_en   = '0;
        alloc_rdy  = '0;
        alloc_rank = '0;
        alloc_cls  = '0;
        if (!squash) begin
            for (int k = 0; k < 3; k++) begin
                if (disp_valid[k] && !struct_stall[k]) begin
                    alloc_en[disp_idx[k]]   = 1'b1;
                    alloc_rdy[disp_idx[k]]  = disp_ready[k];
                    alloc_rank[disp_idx[k]] = 2'(k);
                    alloc_cls[disp_idx[k]]  = disp_class[k];
                end
            end
        end
    end

    // Each slot picks the oldest remaining candidate, then removes the unit it bound.
    always_comb begin
        avail = {!branch_stall, mult_cnt[1] == '0, mult_cnt[0] == '0, !ls_busy[1], !ls_busy[0],
                 !alu_stall[2], !alu_stall[1], !alu_stall[0]};
        taken       = '0;
        fu_issued   = '0;
        issue_valid = '0;
        issue_idx   = '0;
        issue_fu    = '0;
        class_ok    = '0;
        cand        = '0;
        found       = 1'b0;
        older       = 1'b0;
        pick        = '0;
        unit        = '0;
        for (int s = 0; s < 3; s++) begin
            class_ok = {avail[7], |avail[6:5], |avail[4:3], |avail[2:0]};
            for (int i = 0; i < RS_SIZE; i++) begin
                cand[i] = valid[i] & ready[i] & !taken[i] & class_ok[cls[i]];
            end
            found = 1'b0;
            pick  = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (cand[i] && !found) begin
                    older = 1'b1;
                    for (int j = 0; j < RS_SIZE; j++) begin
                        if (j != i && cand[j] && !age[i][j]) older = 1'b0;
                    end
                    if (older) begin
                        found = 1'b1;
                        pick  = IDX_W'(i);
                    end
                end
            end
            if (found) begin
                unit           = first_unit(cls[pick], avail);
                issue_valid[s] = 1'b1;
                issue_idx[s]   = pick;
                issue_fu[s]    = unit;
                avail[unit]    = 1'b0;
                taken[pick]    = 1'b1;
                fu_issued[unit] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid    <= '0;
            ready    <= '0;
            cls      <= '0;
            age      <= '0;
            mult_cnt <= '0;
            ls_busy  <= '0;
        end else if (squash) begin
            valid    <= '0;
            mult_cnt <= '0;
            ls_busy  <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (alloc_en[i]) begin
                    valid[i] <= 1'b1;
                    ready[i] <= alloc_rdy[i];
                    cls[i]   <= alloc_cls[i];
                end else begin
                    valid[i] <= valid[i] & !taken[i];
                    ready[i] <= ready[i] | (valid[i] & wake[i]);
                end
            end
            // New entries are younger than all others; same-cycle ones ordered by slot.
            for (int r = 0; r < RS_SIZE; r++) begin
                for (int c = 0; c < RS_SIZE; c++) begin
                    if (alloc_en[r] && alloc_en[c]) age[r][c] <= (alloc_rank[r] < alloc_rank[c]);
                    else if (alloc_en[r])           age[r][c] <= 1'b0;
                    else if (alloc_en[c])           age[r][c] <= 1'b1;
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (fu_issued[5+j])          mult_cnt[j] <= CW'(MULT_LAT - 1);
                else if (mult_cnt[j] != '0)  mult_cnt[j] <= mult_cnt[j] - CW'(1);
                ls_busy[j] <= fu_issued[3+j] | (ls_busy[j] & !ls_done[j]);
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: expected issues are queued as stimulus is driven and
// matched (cycle, entry, unit) against every issue slot the scheduler raises.
module tb_rs_issue_sched;

    localparam int RS_SIZE = 16;
    localparam int IDX_W   = 4;
    localparam int MULT_LAT = 4;
    localparam logic [1:0] C_ALU = 2'd0, C_LS = 2'd1, C_MUL = 2'd2, C_BR = 2'd3;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  squash = 1'b0;
    logic [2:0]            disp_valid = '0;
    logic [2:0][1:0]       disp_class = '0;
    logic [2:0]            disp_ready = '0;
    logic [2:0][IDX_W-1:0] disp_idx;
    logic [2:0]            struct_stall;
    logic [RS_SIZE-1:0]    wake = '0;
    logic [2:0]            alu_stall = '0;
    logic                  branch_stall = 1'b0;
    logic [1:0]            ls_done = '0;
    logic [2:0]            issue_valid;
    logic [2:0][IDX_W-1:0] issue_idx;
    logic [2:0][2:0]       issue_fu;
    logic [IDX_W:0]        free_count;

    rs_issue_sched #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W), .MULT_LAT(MULT_LAT)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .disp_valid(disp_valid), .disp_class(disp_class), .disp_ready(disp_ready),
        .disp_idx(disp_idx), .struct_stall(struct_stall), .wake(wake),
        .alu_stall(alu_stall), .branch_stall(branch_stall), .ls_done(ls_done),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_fu(issue_fu),
        .free_count(free_count)
    );

    typedef struct {
        int cyc;
        int idx;
        int fu;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [1:0] c0, input logic [1:0] c1,
                         input logic [1:0] c2, input logic [2:0] r);
        disp_valid    = v;
        disp_class[0] = c0;
        disp_class[1] = c1;
        disp_class[2] = c2;
        disp_ready    = r;
    endtask

    task automatic expect_issue(input int c, input int idx, input int fu);
        exp_t e;
        e.cyc = c;
        e.idx = idx;
        e.fu  = fu;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        for (int s = 0; s < 3; s++) begin
            if (issue_valid[s]) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_issue_idx", int'(issue_idx[s]), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("issue_cycle", cyc, mon_e.cyc);
                    check_eq("issue_idx", int'(issue_idx[s]), mon_e.idx);
                    check_eq("issue_fu", int'(issue_fu[s]), mon_e.fu);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_free_count", int'(free_count), 16);
        check_eq("rst_struct_stall", int'(struct_stall), 0);
        check_eq("rst_issue_valid", int'(issue_valid), 0);
        check_eq("rst_disp_idx0", int'(disp_idx[0]), 0);
        reset = 1'b1;
        tick();

        // three ready ALU ops in one cycle
        drive(3'b111, C_ALU, C_ALU, C_ALU, 3'b111);
        #1;
        check_eq("t1_disp_idx0", int'(disp_idx[0]), 0);
        check_eq("t1_disp_idx1", int'(disp_idx[1]), 1);
        check_eq("t1_disp_idx2", int'(disp_idx[2]), 2);
        check_eq("t1_struct_stall", int'(struct_stall), 0);
        expect_issue(cyc + 1, 0, 0);
        expect_issue(cyc + 1, 1, 1);
        expect_issue(cyc + 1, 2, 2);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        #1;
        check_eq("t1_free_during_issue", int'(free_count), 13);
        tick();
        check_eq("t1_free_after", int'(free_count), 16);

        // fill with not-ready MULT, then wake entry 5
        for (int n = 0; n < 5; n++) begin
            drive(3'b111, C_MUL, C_MUL, C_MUL, 3'b000);
            tick();
        end
        drive(3'b001, C_MUL, C_MUL, C_MUL, 3'b000);
        tick();
        drive(3'b000, C_MUL, C_MUL, C_MUL, 3'b000);
        #1;
        check_eq("t2_full_free", int'(free_count), 0);
        check_eq("t2_full_stall", int'(struct_stall), 7);
        wake = 16'h0020;
        drive(3'b111, C_ALU, C_ALU, C_ALU, 3'b111);
        expect_issue(cyc + 1, 5, 5);
        tick();
        wake = '0;
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        #1;
        check_eq("t2_free_issue_cycle", int'(free_count), 0);
        tick();
        check_eq("t2_free_after_issue", int'(free_count), 1);
        check_eq("t2_stall_one_free", int'(struct_stall), 6);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        check_eq("t2_free_after_squash", int'(free_count), 16);

        // four ready MULT: two now, two MULT_LAT cycles later
        t0 = cyc;
        drive(3'b111, C_MUL, C_MUL, C_MUL, 3'b111);
        expect_issue(t0 + 1, 0, 5);
        expect_issue(t0 + 1, 1, 6);
        tick();
        drive(3'b001, C_MUL, C_MUL, C_MUL, 3'b001);
        #1;
        check_eq("t3_disp_idx0", int'(disp_idx[0]), 3);
        expect_issue(t0 + 1 + MULT_LAT, 2, 5);
        expect_issue(t0 + 1 + MULT_LAT, 3, 6);
        tick();
        drive(3'b000, C_MUL, C_MUL, C_MUL, 3'b000);
        repeat (5) tick();
        check_eq("t3_free_after", int'(free_count), 16);

        // LS: busy LS1 forces idx 3 onto LS2; idx 7 waits for ls_done on LS1
        t0 = cyc;
        drive(3'b111, C_LS, C_ALU, C_ALU, 3'b001);
        expect_issue(t0 + 1, 0, 3);
        tick();
        drive(3'b111, C_LS, C_ALU, C_ALU, 3'b001);
        #1;
        check_eq("t4_disp_idx0", int'(disp_idx[0]), 3);
        expect_issue(t0 + 2, 3, 4);
        tick();
        drive(3'b111, C_ALU, C_ALU, C_LS, 3'b100);
        #1;
        check_eq("t4_disp_idx0_reuse", int'(disp_idx[0]), 0);
        check_eq("t4_disp_idx2", int'(disp_idx[2]), 7);
        expect_issue(t0 + 5, 7, 3);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        tick();
        ls_done = 2'b01;
        tick();
        ls_done = 2'b00;
        tick();
        ls_done = 2'b10;
        tick();
        ls_done = 2'b00;
        squash = 1'b1;
        tick();
        squash = 1'b0;
        check_eq("t4_free_after_squash", int'(free_count), 16);

        // mixed classes with the branch unit stalled
        t0 = cyc;
        branch_stall = 1'b1;
        drive(3'b111, C_ALU, C_BR, C_ALU, 3'b010);
        tick();
        drive(3'b001, C_ALU, C_ALU, C_ALU, 3'b000);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        wake = 16'h000D;
        expect_issue(t0 + 3, 0, 0);
        expect_issue(t0 + 3, 2, 1);
        expect_issue(t0 + 3, 3, 2);
        tick();
        wake = '0;
        tick();
        branch_stall = 1'b0;
        expect_issue(t0 + 4, 1, 7);
        tick();
        check_eq("t5_free_after", int'(free_count), 16);
        alu_stall = 3'b011;
        drive(3'b001, C_ALU, C_ALU, C_ALU, 3'b001);
        expect_issue(cyc + 1, 0, 2);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        tick();
        alu_stall = 3'b000;

        // squash with ten valid entries and MULT1 busy
        t0 = cyc;
        for (int n = 0; n < 3; n++) begin
            drive(3'b111, C_ALU, C_ALU, C_ALU, 3'b000);
            tick();
        end
        drive(3'b001, C_MUL, C_ALU, C_ALU, 3'b001);
        expect_issue(t0 + 4, 9, 5);
        tick();
        drive(3'b001, C_ALU, C_ALU, C_ALU, 3'b000);
        #1;
        check_eq("t6_disp_idx0", int'(disp_idx[0]), 10);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        #1;
        check_eq("t6_free_before_squash", int'(free_count), 6);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        #1;
        check_eq("t6_free_after_squash", int'(free_count), 16);
        check_eq("t6_issue_valid", int'(issue_valid), 0);
        drive(3'b001, C_MUL, C_ALU, C_ALU, 3'b001);
        expect_issue(cyc + 1, 0, 5);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        tick();

        // asynchronous reset in the middle of a cycle
        drive(3'b111, C_ALU, C_ALU, C_ALU, 3'b000);
        tick();
        drive(3'b000, C_ALU, C_ALU, C_ALU, 3'b000);
        #1;
        check_eq("t7_free_before_reset", int'(free_count), 13);
        #1;
        reset = 1'b0;
        #1;
        check_eq("t7_free_async_reset", int'(free_count), 16);
        check_eq("t7_stall_async_reset", int'(struct_stall), 0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("t7_free_after_release", int'(free_count), 16);

        check_eq("pending_issues", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
